adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder_pkg.sv | 18 +
 rtl/adc_spi_responder_if.sv | 14 +
 rtl/adc_spi_responder_sync.sv | 32 +++
 rtl/adc_spi_responder.sv | 140 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_responder_pkg.sv
// Shared types and default frame format for the ADC SPI responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_rsp_pkg;

    // Frame FSM: wait for chip enable, shift a frame, then idle until deselect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default frame: 3 leading zeros, 10-bit code, 3 trailing zeros.
    localparam int WORD_SIZE_DEF = 16;
    localparam int CODE_BITS_DEF = 10;
    localparam int LEAD_BITS_DEF = 3;

endpackage

// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between a master and the ADC responder.
// Latency: n/a (wires only).
// Backpressure: none; SPI timing is owned by the master.
// Signals: i_sck serial clock, i_sce chip enable (active low),
//          i_sin master-out data, o_sout slave-out data.
interface adc_spi_responder_if;
    logic i_sck;
    logic i_sce;
    logic i_sin;
    logic o_sout;

    modport master (output i_sck, output i_sce, output i_sin, input o_sout);
    modport slave  (input i_sck, input i_sce, input i_sin, output o_sout);
endinterface

// File: rtl/adc_spi_responder_sync.sv
// 2-flop synchronizer with single-cycle rise/fall pulses on the synced level.
// Latency: 2 i_clk to o_lvl, pulses coincide with the o_lvl change.
// Backpressure: none.
// Ports: i_clk/i_rst, i_async raw input; o_lvl synced level, o_rise/o_fall edge pulses.
module sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_lvl  = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;
endmodule

// File: rtl/adc_spi_responder.sv
// Mode-0 SPI slave emulating an ADC: returns the held code, captures MOSI words.
// Latency: raw SCK fall to o_sout valid in 3 i_clk; o_wstb 3 i_clk after last raw SCK rise.
// Backpressure: none; SCK half-periods must be >= 5 i_clk.
// Ports: i_clk/i_rst; spi (slave modport: i_sck, i_sce, i_sin, o_sout);
//        i_code/i_code_vld load the holding register; o_wout/o_wstb last received word;
//        o_busy high while the FSM is not IDLE.
// Build option: ADC_RSP_RAMP_EN makes the held code increment after every completed frame.
module adc_spi_responder
    import adc_rsp_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF,
    parameter int CODE_BITS = CODE_BITS_DEF,
    parameter int LEAD_BITS = LEAD_BITS_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    adc_spi_responder_if.slave     spi,
    input  logic [CODE_BITS-1:0]   i_code,
    input  logic                   i_code_vld,
    output logic [WORD_SIZE-1:0]   o_wout,
    output logic                   o_wstb,
    output logic                   o_busy
);
    localparam int TRAIL_BITS = WORD_SIZE - LEAD_BITS - CODE_BITS;
    localparam int CNT_W      = $clog2(WORD_SIZE + 1);

    logic w_sck_rise, w_sck_fall, w_sck_lvl_unused;
    logic w_sce_rise, w_sce_fall, w_sce_lvl_unused;
    logic w_sin, w_sin_rise_unused, w_sin_fall_unused;

    sync_edge u_sck (.i_clk(i_clk), .i_rst(i_rst), .i_async(spi.i_sck),
                     .o_lvl(w_sck_lvl_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
    sync_edge u_sce (.i_clk(i_clk), .i_rst(i_rst), .i_async(spi.i_sce),
                     .o_lvl(w_sce_lvl_unused), .o_rise(w_sce_rise), .o_fall(w_sce_fall));
    sync_edge u_sin (.i_clk(i_clk), .i_rst(i_rst), .i_async(spi.i_sin),
                     .o_lvl(w_sin), .o_rise(w_sin_rise_unused), .o_fall(w_sin_fall_unused));

    state_t                 r_state, w_next;
    logic [CODE_BITS-1:0]   r_hold;
    logic [WORD_SIZE-1:0]   r_tx;
    logic [WORD_SIZE-2:0]   r_rx;      // bits received so far; the last bit is taken live
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_sout;
    logic [WORD_SIZE-1:0]   r_wout;
    logic                   r_wstb;

    logic                   w_load, w_rx_step, w_tx_step, w_word_done;
    logic [WORD_SIZE-1:0]   w_frame;
    logic [WORD_SIZE-1:0]   w_rx_word;

    assign w_frame   = WORD_SIZE'(r_hold) << TRAIL_BITS;
    assign w_rx_word = {r_rx, w_sin};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Deselect always wins over a coincident SCK edge so an abort never strobes.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_rx_step   = 1'b0;
        w_tx_step   = 1'b0;
        w_word_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_sce_fall) begin
                    w_next = SHIFT;
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (w_sce_rise) begin
                    w_next = IDLE;
                end else begin
                    if (w_sck_rise) begin
                        w_rx_step = 1'b1;
                        if (r_cnt == CNT_W'(WORD_SIZE - 1)) begin
                            w_word_done = 1'b1;
                            w_next      = DONE;
                        end
                    end
                    w_tx_step = w_sck_fall;
                end
            end
            DONE: begin
                if (w_sce_rise) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx   <= '0;
            r_rx   <= '0;
            r_cnt  <= '0;
            r_sout <= 1'b0;
            r_wout <= '0;
            r_wstb <= 1'b0;
        end else begin
            r_wstb <= w_word_done;
            // MSB goes straight to the pin on select; the shifter keeps the rest.
            if (w_load) begin
                r_sout <= w_frame[WORD_SIZE-1];
                r_tx   <= {w_frame[WORD_SIZE-2:0], 1'b0};
                r_cnt  <= '0;
            end else if (w_next != SHIFT) begin
                r_sout <= 1'b0;
            end else if (w_tx_step) begin
                r_sout <= r_tx[WORD_SIZE-1];
                r_tx   <= {r_tx[WORD_SIZE-2:0], 1'b0};
            end
            if (w_rx_step) begin
                r_rx  <= w_rx_word[WORD_SIZE-2:0];
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_word_done) r_wout <= w_rx_word;
        end
    end

    // The frame copies r_hold at select time, so later loads only affect the next frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (i_code_vld) begin
            r_hold <= i_code;
`ifdef ADC_RSP_RAMP_EN
        end else if (r_wstb) begin
            r_hold <= r_hold + CODE_BITS'(1);
`endif
        end
    end

    assign spi.o_sout = r_sout;
    assign o_wout     = r_wout;
    assign o_wstb     = r_wstb;
    assign o_busy     = (r_state != IDLE);
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder acting as a mode-0 SPI master.
// Latency: SCK half-period of 6 i_clk leaves margin over the responder delay.
// Backpressure: n/a; all waits are fixed cycle counts plus a global watchdog.
module tb_adc_spi_responder;
    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  code;
    logic        code_vld;
    logic [15:0] wout;
    logic        wstb;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int wstb_cnt = 0;

    logic        ovr_en;
    logic [9:0]  ovr_code;

    adc_spi_responder_if spi_if ();

    adc_spi_responder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .spi        (spi_if),
        .i_code     (code),
        .i_code_vld (code_vld),
        .o_wout     (wout),
        .o_wstb     (wstb),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wstb) wstb_cnt <= wstb_cnt + 1;

    initial begin
        #10000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic half();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic load(input logic [9:0] c);
        @(negedge clk);
        code = c;
        code_vld = 1'b1;
        @(negedge clk);
        code_vld = 1'b0;
    endtask

    // One SCK period; samples o_sout at the rise and optionally loads a code on o_wstb.
    task automatic sck_bit(input logic b, output logic s);
        spi_if.i_sin = b;
        half();
        spi_if.i_sck = 1'b1;
        s = spi_if.o_sout;
        for (int k = 0; k < HALF; k++) begin
            @(negedge clk);
            if (ovr_en && wstb) begin
                code = ovr_code;
                code_vld = 1'b1;
                ovr_en = 1'b0;
            end else begin
                code_vld = 1'b0;
            end
        end
        spi_if.i_sck = 1'b0;
    endtask

    // load_at: -1 none, -2 pulse i_code_vld on the cycle the responder sees SCE fall,
    // otherwise pulse before that bit index.
    task automatic frame(input logic [15:0] mosi, input int nbits, input int load_at,
                         input logic [9:0] lc, output logic [15:0] miso, output logic extra_or);
        logic [15:0] m;
        logic s;
        m = mosi;
        miso = '0;
        extra_or = 1'b0;
        spi_if.i_sce = 1'b0;
        if (load_at == -2) begin
            @(negedge clk);
            @(negedge clk);
            code = lc;
            code_vld = 1'b1;
            @(negedge clk);
            code_vld = 1'b0;
            repeat (HALF - 3) @(negedge clk);
        end else begin
            half();
        end
        chk("busy_on", 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == load_at) load(lc);
            sck_bit(m[15], s);
            m = {m[14:0], 1'b0};
            if (i < 16) miso = {miso[14:0], s};
            else        extra_or = extra_or | s;
        end
        half();
        spi_if.i_sce = 1'b1;
        half();
        chk("busy_off", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        xo;
        int          w0;
        rst = 1'b1;
        code = '0;
        code_vld = 1'b0;
        ovr_en = 1'b0;
        ovr_code = '0;
        spi_if.i_sck = 1'b0;
        spi_if.i_sce = 1'b1;
        spi_if.i_sin = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_sout", 32'(spi_if.o_sout), 32'd0);
        chk("rst_wstb", 32'(wstb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wout", 32'(wout), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

`ifdef ADC_RSP_RAMP_EN
        load(10'h3FE);
        frame(16'h1111, 16, -1, 10'h0, rd, xo);
        chk("ramp_a1", 32'(rd), 32'h1FF0);
        frame(16'h2222, 16, -1, 10'h0, rd, xo);
        chk("ramp_a2", 32'(rd), 32'h1FF8);
        frame(16'h3333, 16, -1, 10'h0, rd, xo);
        chk("ramp_a3", 32'(rd), 32'h0000);
        chk("ramp_wout", 32'(wout), 32'h3333);

        load(10'h3FE);
        frame(16'h4444, 16, -1, 10'h0, rd, xo);
        chk("ramp_b1", 32'(rd), 32'h1FF0);
        ovr_en = 1'b1;
        ovr_code = 10'h100;
        frame(16'h5555, 16, -1, 10'h0, rd, xo);
        chk("ramp_b2", 32'(rd), 32'h1FF8);
        frame(16'h6666, 16, -1, 10'h0, rd, xo);
        chk("ramp_b3", 32'(rd), 32'h0800);
`else
        // Basic frame.
        load(10'h2A5);
        w0 = wstb_cnt;
        frame(16'hBEEF, 16, -1, 10'h0, rd, xo);
        chk("f1_miso", 32'(rd), 32'h1528);
        chk("f1_wout", 32'(wout), 32'hBEEF);
        chk("f1_wstb", 32'(wstb_cnt - w0), 32'd1);

        // Mid-frame load applies only to the next frame.
        load(10'h3FF);
        frame(16'h1234, 16, 5, 10'h000, rd, xo);
        chk("mid_miso", 32'(rd), 32'h1FF8);
        chk("mid_wout", 32'(wout), 32'h1234);

        // Load coincident with select: this frame still sends the old code.
        frame(16'hA5A5, 16, -2, 10'h155, rd, xo);
        chk("next_miso", 32'(rd), 32'h0000);
        chk("next_wout", 32'(wout), 32'hA5A5);

        // Abort after 7 rises.
        w0 = wstb_cnt;
        frame(16'hFFFF, 7, -1, 10'h0, rd, xo);
        chk("abort_wstb", 32'(wstb_cnt - w0), 32'd0);
        chk("abort_wout", 32'(wout), 32'hA5A5);
        frame(16'h0F0F, 16, -1, 10'h0, rd, xo);
        chk("post_abort_miso", 32'(rd), 32'h0AA8);
        chk("post_abort_wout", 32'(wout), 32'h0F0F);

        // Extra clocks after the last bit.
        w0 = wstb_cnt;
        frame(16'hC3C3, 20, -1, 10'h0, rd, xo);
        chk("extra_miso", 32'(rd), 32'h0AA8);
        chk("extra_sout", 32'(xo), 32'd0);
        chk("extra_wstb", 32'(wstb_cnt - w0), 32'd1);
        chk("extra_wout", 32'(wout), 32'hC3C3);

        // Reset in the middle of a frame.
        w0 = wstb_cnt;
        spi_if.i_sce = 1'b0;
        half();
        for (int i = 0; i < 5; i++) begin
            logic s;
            sck_bit(1'b1, s);
        end
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_sout", 32'(spi_if.o_sout), 32'd0);
        chk("mrst_wstb", 32'(wstb), 32'd0);
        chk("mrst_wout", 32'(wout), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        spi_if.i_sce = 1'b1;
        half();
        chk("mrst_nostb", 32'(wstb_cnt - w0), 32'd0);
        load(10'h2A5);
        frame(16'hBEEF, 16, -1, 10'h0, rd, xo);
        chk("mrst_miso", 32'(rd), 32'h1528);
        chk("mrst_fwout", 32'(wout), 32'hBEEF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
